// File: rtl/ripple_count_capture.sv
// Brings an asynchronous ripple-counter bus into the clk domain, filters ripple glitches
// and extends it with a wrap count; accept lands STABLE+1 edges after q_in settles.
module ripple_count_capture #(
   parameter int WIDTH  = 4,
   parameter int EXT    = 4,
   parameter int STABLE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       q_in,
   input  logic                   clr,
   input  logic [WIDTH+EXT-1:0]   thresh,
   output logic [WIDTH+EXT-1:0]   count,
   output logic                   valid,
   output logic                   wrap,
   output logic                   err,
   output logic                   match
);

   localparam int STAB_W = (STABLE > 2) ? $clog2(STABLE) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE - 1);

   logic [WIDTH-1:0]  s1_q, s2_q, s3_q;
   logic [STAB_W-1:0] stab_q, stab_d;
   logic [WIDTH-1:0]  acc_q, acc_d;
   logic [EXT-1:0]    ext_q, ext_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic              match_q, match_d;

   logic              same;
   logic              stab_ok;
   logic              accept;
   logic [WIDTH-1:0]  acc_inc;

   assign same    = (s2_q == s3_q);
   assign acc_inc = acc_q + 1'b1;

   // With STABLE == 2 the s2/s3 equality alone is the whole filter.
   if (STABLE <= 2) begin : g_stab_min
      assign stab_ok = 1'b1;
   end else begin : g_stab_cmp
      assign stab_ok = (stab_q >= STAB_W'(STABLE - 2));
   end

   assign accept = same && stab_ok && (s2_q != acc_q) && !clr;

   always_comb begin
      stab_d  = stab_q;
      acc_d   = acc_q;
      ext_d   = ext_q;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      err_d   = err_q;
      match_d = ({ext_q, acc_q} >= thresh);

      if (!same) begin
         stab_d = '0;
      end else if (stab_q != STAB_MAX) begin
         stab_d = stab_q + 1'b1;
      end

      // clr rebaselines on whatever is in s2, absorbing a coincident accept.
      if (clr) begin
         acc_d = s2_q;
         ext_d = '0;
         err_d = 1'b0;
      end else if (accept) begin
         acc_d   = s2_q;
         valid_d = 1'b1;
         if (s2_q < acc_q) begin
            ext_d  = ext_q + 1'b1;
            wrap_d = 1'b1;
         end
         if (s2_q != acc_inc) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s3_q    <= '0;
         stab_q  <= '0;
         acc_q   <= '0;
         ext_q   <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         err_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         s1_q    <= q_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         stab_q  <= stab_d;
         acc_q   <= acc_d;
         ext_q   <= ext_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
         match_q <= match_d;
      end
   end

   assign count = {ext_q, acc_q};
   assign valid = valid_q;
   assign wrap  = wrap_q;
   assign err   = err_q;
   assign match = match_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture: expected accepts are queued by the
// stimulus and popped by a negedge monitor whenever valid pulses.
module tb_ripple_count_capture;

   typedef struct packed {
      logic [7:0] cnt;
      logic       wr;
      logic       er;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] q_in;
   logic       clr;
   logic [7:0] thresh;
   logic [7:0] count;
   logic       valid, wrap, err, match;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   ripple_count_capture #(.WIDTH(4), .EXT(4), .STABLE(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .q_in   (q_in),
      .clr    (clr),
      .thresh (thresh),
      .count  (count),
      .valid  (valid),
      .wrap   (wrap),
      .err    (err),
      .match  (match)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Queue the expected accept, then hold q_in for six cycles.
   task automatic step(input logic [3:0] v, input logic [7:0] c, input logic w, input logic e);
      exp_t x;
      x.cnt = c;
      x.wr  = w;
      x.er  = e;
      exp_q.push_back(x);
      q_in = v;
      repeat (6) @(posedge clk);
      #1;
   endtask

   // Monitor: every valid pulse must match the oldest queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (!rst && valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_valid: got count=%h with empty queue, required no pulse", count);
            end else begin
               x = exp_q.pop_front();
               n_vec++;
               if ({count, wrap, err} !== {x.cnt, x.wr, x.er}) begin
                  n_err++;
                  $display("FAIL accept: got count=%h wrap=%b err=%b expected count=%h wrap=%b err=%b",
                           count, wrap, err, x.cnt, x.wr, x.er);
               end
            end
         end
      end
   end

   initial begin
      int first;
      int pulses;
      bit found;

      rst    = 1'b1;
      q_in   = 4'h5;
      clr    = 1'b0;
      thresh = 8'h00;

      // 1: reset state, then quiet release
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", count, 8'h00);
      check("rst_flags", {4'b0, valid, wrap, err, match}, 8'h00);
      q_in = 4'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_match", {7'b0, match}, 8'h01);
      thresh = 8'hFF;
      repeat (10) @(posedge clk);
      #1;
      check("idle_count", count, 8'h00);
      check("idle_match", {7'b0, match}, 8'h00);

      // 2: clean step with latency measurement
      begin
         exp_t x;
         x.cnt = 8'h01; x.wr = 1'b0; x.er = 1'b0;
         exp_q.push_back(x);
      end
      q_in   = 4'h1;
      first  = 0;
      pulses = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      check("latency", 8'(first), 8'd4);
      check("pulse_cnt", 8'(pulses), 8'd1);
      check("step_count", count, 8'h01);

      // 3: ripple glitch 7 -> 0 (one period) -> 8
      for (int v = 2; v <= 7; v++) step(4'(v), 8'(v), 1'b0, 1'b0);
      q_in = 4'h0;
      @(posedge clk);
      #1;
      step(4'h8, 8'h08, 1'b0, 1'b0);
      check("glitch_count", count, 8'h08);
      check("glitch_err", {7'b0, err}, 8'h00);

      // 4: rebaseline to 0 under clr, then a full wrap
      clr  = 1'b1;
      q_in = 4'h0;
      repeat (6) @(posedge clk);
      #1;
      clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("clr0_count", count, 8'h00);
      for (int v = 1; v <= 15; v++) step(4'(v), 8'(v), 1'b0, 1'b0);
      step(4'h0, 8'h10, 1'b1, 1'b0);
      check("wrap_count", count, 8'h10);

      // 5: skip sets sticky err, clr drops it
      step(4'h1, 8'h11, 1'b0, 1'b0);
      step(4'h2, 8'h12, 1'b0, 1'b0);
      step(4'h3, 8'h13, 1'b0, 1'b0);
      step(4'h5, 8'h15, 1'b0, 1'b1);
      step(4'h6, 8'h16, 1'b0, 1'b1);
      step(4'h7, 8'h17, 1'b0, 1'b1);
      check("err_sticky", {7'b0, err}, 8'h01);
      clr  = 1'b1;
      q_in = 4'h5;
      repeat (6) @(posedge clk);
      #1;
      clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("clr_count", count, 8'h05);
      check("clr_err", {7'b0, err}, 8'h00);

      // 6: match threshold and asynchronous reset
      thresh = 8'h12;
      for (int v = 6; v <= 15; v++) step(4'(v), 8'(v), 1'b0, 1'b0);
      step(4'h0, 8'h10, 1'b1, 1'b0);
      step(4'h1, 8'h11, 1'b0, 1'b0);
      check("match_below", {7'b0, match}, 8'h00);
      begin
         exp_t x;
         x.cnt = 8'h12; x.wr = 1'b0; x.er = 1'b0;
         exp_q.push_back(x);
      end
      q_in  = 4'h2;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(posedge clk);
         #1;
         if (valid) found = 1'b1;
      end
      check("match_valid_seen", {7'b0, found}, 8'h01);
      check("match_lag", {7'b0, match}, 8'h00);
      @(posedge clk);
      #1;
      check("match_hit", {7'b0, match}, 8'h01);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_count", count, 8'h00);
      check("async_rst_match", {7'b0, match}, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Downstream consumer of the 4-bit asynchronous JK ripple up-counter. It samples the counter's `q` bus, which ripples and is asynchronous to the system clock, into the `clk` domain and rejects ripple glitches with a stability filter. It extends the accepted value with wrap-counted upper bits and flags skipped counts and threshold matches. It is the point where the ripple counter's output becomes a trustworthy synchronous value for the rest of the design.

## Interface
- `WIDTH`, 4: width of the ripple counter bus `q_in`.
- `EXT`, 4: number of extension bits counting wraps of `q_in`.
- `STABLE`, 2: consecutive identical synchronised samples required to accept a value. Must be ≥ 2.

- `clk` input, 1: system clock; all state is on the rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `q_in` input, WIDTH: ripple counter output, asynchronous to `clk`.
- `clr` input, 1: synchronous clear and rebaseline.
- `thresh` input, WIDTH+EXT: compare threshold.
- `count` output, WIDTH+EXT: `{ext, acc}`, the accepted extended count.
- `valid` output, 1: one-cycle pulse when a new value is accepted.
- `wrap` output, 1: one-cycle pulse, coincident with `valid`, when `acc` wraps.
- `err` output, 1: sticky flag; an accepted value is not the previous value + 1.
- `match` output, 1: registered level, `count >= thresh` (unsigned).

## Operation
- **Synchroniser:** `s1 <= q_in`, `s2 <= s1`, `s3 <= s2` every edge. Only `s2` and `s3` feed logic.
- **Stability counter `stab`:**
  - If `s2 == s3`, `stab <= min(stab+1, STABLE-1)`; otherwise `stab <= 0`.
  - `stab` is ceil(log2(STABLE)) bits wide.
- **Accept condition:** `s2 == s3 && stab >= STABLE-2 && s2 != acc && !clr`.
- **On accept:**
  - `acc <= s2`.
  - `valid <= 1`.
  - If `s2 < acc` (unsigned), then `ext <= ext+1` (mod 2^EXT) and `wrap <= 1`.
  - If `s2 != acc+1` (mod 2^WIDTH), then `err <= 1`.
- **Otherwise:** `valid` and `wrap` return to 0 the next edge.
- **Filter states:** SETTLING (`stab < STABLE-2` or `s2 != s3`), then STABLE, then ACCEPT (single cycle), then back to STABLE. Any change of `s2` returns the filter to SETTLING.
- **`clr` (synchronous, highest priority after `rst`):**
  - `ext <= 0`, `err <= 0`, `acc <= s2`.
  - `valid <= 0`, `wrap <= 0`; `stab` is unaffected.
  - `count` becomes `{0, s2}` with no `valid` pulse.
- **Clear/accept collision:** if `clr` and an accept condition coincide, `clr` wins and the sample is absorbed as the new baseline.
- **Match:** `match <= ({ext,acc} >= thresh)`, evaluated every edge on current register values.
- **Arithmetic:** unsigned throughout. `ext` wraps silently; overflow of `ext` is not flagged.

## Timing
- **Reset (`rst` = 1):** takes effect immediately, independent of `clk`. `s1`, `s2`, `s3`, `stab`, `acc`, `ext`, `valid`, `wrap`, `err` and `match` all become 0, so `count` = 0.
- **Post-reset `match`:** the first edge after release evaluates `match`. With `thresh` = 0 it reads 1 from that edge.
- **Latency:** `q_in` stable before edge E, then `acc`/`valid` update at edge E+STABLE+1. That is 4 edges for `STABLE`=2: s1 at E, s2 at E+1, s3 at E+2, accept at E+3.
- **Glitch rejection:** a value seen in `s2` for fewer than STABLE consecutive edges is never accepted. This covers intermediate ripple codes such as 0111→0110→0100→0000→1000.
- **Throughput:** at most one accept per STABLE edges. `q_in` must hold each value at least STABLE+2 clk periods for guaranteed capture; faster input sets `err`.
- **`match` latency:** lags `count` by one edge.
- **Reset mid-operation:** any in-flight accept is discarded; no `valid` pulse occurs after reset release unless `q_in` ≠ 0.

## Test plan
1. **Reset:** hold `rst`=1 with `q_in`=4'h5 and toggle `clk` → all outputs 0. Release with `q_in`=0 for 10 cycles → `valid` never pulses and `count`=8'h00.
2. **Clean step:** `q_in` 0→1, held 10 cycles → exactly one `valid` pulse, 4 edges after the change. `count`=8'h01, `wrap`=0, `err`=0.
3. **Ripple glitch:** `acc`=7; drive `q_in`=4'h0 for one clk period, then 4'h8 held → no accept of 0, `count` goes 8'h07→8'h08, `wrap`=0, `err`=0.
4. **Wrap:** step `q_in` 0..15 then 0, each held 6 cycles → 16 `valid` pulses. `wrap` pulses only with the final accept, and `count`=8'h10 at the end.
5. **Skip and clear:** from `acc`=3, step `q_in` to 5 → `err`=1 and stays 1 over further valid steps. Pulse `clr` with `q_in`=5 → `err`=0, `count`=8'h05, no `valid`.
6. **Match and async reset:** `thresh`=8'h12; advance to `count`=8'h12 → `match`=1 one edge later. Assert `rst` between clock edges → `count`=0 and `match`=0 immediately, before the next edge.
